// File: rtl/uart_pkg.sv
// Shared UART line definitions: FSM state encoding, parity codes and frame helpers.
// Used by both the transmitter and the companion receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'b00,
    PAR_EVEN  = 2'b01,
    PAR_ODD   = 2'b10,
    PAR_SPACE = 2'b11
  } parity_t;

  localparam int FRAME_W = 12;

  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] sel);
    logic p;
    p = 1'b0;
    if (sel == PAR_EVEN) p = ^data;
    else if (sel == PAR_ODD) p = ~^data;
    return p;
  endfunction

  // Frame image, bit 0 first on the line; unused tail bits stay 1 so they double as stop bits.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [7:0] data, input logic [1:0] sel);
    logic [FRAME_W-1:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = data;
    if (sel != PAR_NONE) f[9] = parity_bit(data, sel);
    return f;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Show-ahead synchronous FIFO with registered full/empty; head valid whenever not empty.
// Zero-latency read of head; pushes while full and pops while empty are ignored.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic         mclk,
  input  logic         n_reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok) count_nxt = count + CNT_ONE;
    else if (pop_ok && !push_ok) count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge mclk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok) rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
      full  <= (count_nxt == CNT_FULL);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge mclk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered bytes serialized as start/8 data LSB first/parity/stop bits.
// Start bit leaves 2 cycles after the FIFO goes non-empty; writes while full are dropped and flagged on wr_err.
module uart_tx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        mclk,
  input  logic        n_reset,
  input  logic [15:0] baudrate,
  input  logic [1:0]  parity_sel,
  input  logic        stop_sel,
  input  logic        wr_en,
  input  logic [7:0]  wdata,
  output logic        tx_full,
  output logic        tx_empty,
  output logic        wr_err,
  output logic        busy,
  output logic        txd
);

  state_t               state;
  state_t               state_nxt;
  logic [15:0]          baud_q;
  logic [15:0]          cnt1;
  logic [3:0]           cnt2;
  logic [3:0]           last_idx;
  logic [FRAME_W-1:0]   shreg;
  logic [FRAME_W-1:0]   frame;
  logic [7:0]           fifo_head;
  logic                 fifo_pop;
  logic                 bit_end;
  logic                 last_bit;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .mclk    (mclk),
    .n_reset (n_reset),
    .push    (wr_en),
    .pop     (fifo_pop),
    .wdata   (wdata),
    .head    (fifo_head),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  assign busy     = (state != IDLE);
  assign bit_end  = (cnt1 == baud_q);
  assign last_bit = bit_end && (cnt2 == last_idx);
  assign frame    = build_frame(fifo_head, parity_sel);

  always_ff @(posedge mclk or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    case (state)
      IDLE: if (!tx_empty) state_nxt = LOAD;
      LOAD: begin
        fifo_pop  = 1'b1;
        state_nxt = SEND;
      end
      SEND: if (last_bit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Line configuration is captured in LOAD so later changes only affect the next frame.
  always_ff @(posedge mclk or negedge n_reset) begin
    if (!n_reset) begin
      txd      <= 1'b1;
      baud_q   <= '0;
      cnt1     <= '0;
      cnt2     <= '0;
      last_idx <= '0;
      shreg    <= '1;
      wr_err   <= 1'b0;
    end else begin
      wr_err <= wr_en && tx_full;
      case (state)
        LOAD: begin
          baud_q   <= baudrate;
          last_idx <= 4'd9 + {3'b000, (parity_sel != PAR_NONE)} + {3'b000, stop_sel};
          shreg    <= {1'b1, frame[FRAME_W-1:1]};
          txd      <= frame[0];
          cnt1     <= '0;
          cnt2     <= '0;
        end
        SEND: begin
          if (bit_end) begin
            cnt1 <= '0;
            if (cnt2 == last_idx) begin
              txd  <= 1'b1;
              cnt2 <= '0;
            end else begin
              txd   <= shreg[0];
              shreg <= {1'b1, shreg[FRAME_W-1:1]};
              cnt2  <= cnt2 + 4'd1;
            end
          end else begin
            cnt1 <= cnt1 + 16'd1;
          end
        end
        default: begin
          txd  <= 1'b1;
          cnt1 <= '0;
          cnt2 <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a line monitor decodes txd and compares.
module tb_uart_tx;

  logic        mclk;
  logic        n_reset;
  logic [15:0] baudrate;
  logic [1:0]  parity_sel;
  logic        stop_sel;
  logic        wr_en;
  logic [7:0]  wdata;
  logic        tx_full;
  logic        tx_empty;
  logic        wr_err;
  logic        busy;
  logic        txd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [11:0] bits;
    int          len;
    int          baud;
    int          wr_cyc;
  } exp_t;

  exp_t exp_q[$];

  uart_tx #(.FIFO_DEPTH(16)) dut (
    .mclk       (mclk),
    .n_reset    (n_reset),
    .baudrate   (baudrate),
    .parity_sel (parity_sel),
    .stop_sel   (stop_sel),
    .wr_en      (wr_en),
    .wdata      (wdata),
    .tx_full    (tx_full),
    .tx_empty   (tx_empty),
    .wr_err     (wr_err),
    .busy       (busy),
    .txd        (txd)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;
  always @(posedge mclk) cyc <= cyc + 1;

  // Reference frame: the line sequence a UART frame should carry, as a list of bits.
  function automatic exp_t model(input logic [7:0] d, input logic [1:0] par, input logic st, input int eb);
    exp_t e;
    int n;
    e.bits = '1;
    e.bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < 8; i++) begin
      e.bits[n] = d[i];
      n++;
    end
    if (par != 2'b00) begin
      if (par == 2'b01) e.bits[n] = ^d;
      else if (par == 2'b10) e.bits[n] = ~^d;
      else e.bits[n] = 1'b0;
      n++;
    end
    n = n + 1 + (st ? 1 : 0);
    e.len = n;
    e.baud = eb;
    e.wr_cyc = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input int eb, input bit acc);
    exp_t e;
    wr_en = 1'b1;
    wdata = d;
    if (acc) begin
      e = model(d, parity_sel, stop_sel, eb);
      e.wr_cyc = cyc;
      exp_q.push_back(e);
    end
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_txd_low(input string tag);
    int k;
    k = 0;
    while (txd !== 1'b0 && k < 300) begin
      tick();
      k++;
    end
    chk({tag, "_start_seen"}, txd, 1'b0);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 6000) begin
      tick();
      k++;
    end
    chk({tag, "_drained"}, (k >= 6000), 1'b0);
    if (k >= 6000) exp_q.delete();
    repeat (4) tick();
  endtask

  // Line monitor: decodes every frame on txd and checks it against the head of the scoreboard.
  initial begin : monitor
    exp_t        e;
    logic        prev;
    logic [11:0] got;
    int          gap;
    int          last_end;
    bit          ok;
    bit          aborted;
    prev = 1'b1;
    gap = 1000;
    last_end = -1;
    forever begin
      @(negedge mclk);
      if (!n_reset) begin
        prev = 1'b1;
        gap = 1000;
        continue;
      end
      if (prev && !txd) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: start bit with empty scoreboard at cycle %0d", cyc);
          for (int k = 0; k < 2000 && txd == 1'b0; k++) @(negedge mclk);
          prev = txd;
          gap = 0;
          continue;
        end
        e = exp_q.pop_front();
        if (e.wr_cyc < last_end) begin
          checks++;
          if (gap != 2) begin
            errors++;
            $display("FAIL interframe_gap: got %0d idle cycles expected 2 at cycle %0d", gap, cyc);
          end
        end
        ok = 1'b1;
        aborted = 1'b0;
        got = '1;
        for (int i = 0; i < e.len && !aborted; i++) begin
          for (int c = 0; c <= e.baud && !aborted; c++) begin
            if (i != 0 || c != 0) @(negedge mclk);
            if (!n_reset) aborted = 1'b1;
            else begin
              if (txd !== e.bits[i]) ok = 1'b0;
              if (busy !== 1'b1) ok = 1'b0;
              if (c == 0) got[i] = txd;
            end
          end
        end
        if (aborted) begin
          prev = 1'b1;
          gap = 1000;
          continue;
        end
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL frame: got bits %03h expected %03h len %0d baud %0d at cycle %0d",
                   got, e.bits, e.len, e.baud, cyc);
        end
        @(negedge mclk);
        checks++;
        if (busy !== 1'b0 || txd !== 1'b1) begin
          errors++;
          $display("FAIL frame_end: got busy %0b txd %0b expected busy 0 txd 1 at cycle %0d", busy, txd, cyc);
        end
        last_end = cyc;
        gap = 1;
        prev = txd;
      end else begin
        if (txd) gap++;
        prev = txd;
      end
    end
  end

  initial begin : stimulus
    bit seen_low;
    int nb;
    n_reset = 1'b0;
    baudrate = 16'd3;
    parity_sel = 2'b00;
    stop_sel = 1'b0;
    wr_en = 1'b0;
    wdata = 8'h00;
    repeat (3) @(posedge mclk);
    #1;
    chk("rst_tx_full", tx_full, 1'b0);
    chk("rst_tx_empty", tx_empty, 1'b1);
    chk("rst_wr_err", wr_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_txd", txd, 1'b1);
    n_reset = 1'b1;
    tick();
    tick();

    // First write into an idle block, with edge-accurate latency checks.
    wr(8'h55, 3, 1'b1);
    chk("lat_empty_falls", tx_empty, 1'b0);
    chk("lat_busy_before_load", busy, 1'b0);
    tick();
    chk("lat_busy_rises", busy, 1'b1);
    chk("lat_txd_high_in_load", txd, 1'b1);
    tick();
    chk("lat_txd_falls", txd, 1'b0);
    chk("lat_popped", tx_empty, 1'b1);
    wait_idle("f55");

    // Parity modes and two stop bits.
    baudrate = 16'd2;
    parity_sel = 2'b01; wr(8'hA5, 2, 1'b1); wait_idle("par_even");
    parity_sel = 2'b10; wr(8'hA5, 2, 1'b1); wait_idle("par_odd");
    parity_sel = 2'b11; wr(8'hA5, 2, 1'b1); wait_idle("par_space");
    parity_sel = 2'b01; stop_sel = 1'b1; wr(8'h01, 2, 1'b1); wait_idle("stop2");

    // Fill the FIFO while a frame is on the line.
    baudrate = 16'd3; parity_sel = 2'b00; stop_sel = 1'b0;
    wr(8'h11, 3, 1'b1);
    wait_txd_low("fill");
    for (int i = 0; i < 17; i++) begin
      wr(8'h20 + 8'(i), 3, (i < 16));
      if (i == 14) chk("full_after_15", tx_full, 1'b0);
      if (i == 15) begin
        chk("full_after_16", tx_full, 1'b1);
        chk("no_err_on_16", wr_err, 1'b0);
      end
      if (i == 16) chk("err_on_17", wr_err, 1'b1);
    end
    chk("still_full", tx_full, 1'b1);
    tick();
    chk("err_one_cycle", wr_err, 1'b0);
    wait_idle("fill");

    // Baud change mid-frame only affects the next frame.
    wr(8'hA1, 3, 1'b1);
    wr(8'hB2, 7, 1'b1);
    wait_txd_low("baud");
    repeat (6) tick();
    baudrate = 16'd7;
    wait_idle("baud");

    // Randomized frames with random line configuration, sometimes back-to-back.
    for (int r = 0; r < 10; r++) begin
      parity_sel = 2'($urandom_range(0, 3));
      stop_sel = 1'($urandom_range(0, 1));
      baudrate = 16'($urandom_range(0, 5));
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) wr(8'($urandom), int'(baudrate), 1'b1);
      wait_idle("rand");
    end

    // Reset in the middle of d3 with another byte still queued.
    baudrate = 16'd3; parity_sel = 2'b00; stop_sel = 1'b0;
    wr(8'hC3, 3, 1'b1);
    wr(8'h3C, 3, 1'b1);
    wait_txd_low("rst");
    repeat (17) tick();
    #2;
    n_reset = 1'b0;
    #1;
    chk("midrst_txd", txd, 1'b1);
    chk("midrst_empty", tx_empty, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    exp_q.delete();
    repeat (3) tick();
    n_reset = 1'b1;
    seen_low = 1'b0;
    repeat (100) begin
      tick();
      if (txd !== 1'b1) seen_low = 1'b1;
    end
    chk("no_resume_after_rst", seen_low, 1'b0);
    chk("idle_after_rst", busy, 1'b0);

    wr(8'h5A, 3, 1'b1);
    wait_idle("recover");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter for the UART loopback design. Bytes written by the host are buffered in a 16-entry FIFO and serialized onto `txd` as start / 8 data (LSB first) / optional parity / 1–2 stop frames. Line configuration matches the companion receiver, so `txd` can be wired straight to its `rxd` for loopback.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: TX FIFO depth in bytes. Must be a power of two.

Ports:
- `mclk` in 1: system clock.
- `n_reset` in 1: reset, asynchronous, active-low.
- `baudrate` in 16: bit period minus one, in `mclk` cycles. Each bit lasts `baudrate+1` cycles.
- `parity_sel` in 2: parity mode.
  - 00: none.
  - 01: even; parity bit = XOR of the data bits.
  - 10: odd; parity bit = ~XOR of the data bits.
  - 11: constant 0 (space).
- `stop_sel` in 1: 0 = one stop bit, 1 = two stop bits.
- `wr_en` in 1: write strobe; pushes `wdata` into the FIFO.
- `wdata` in 8: byte to transmit.
- `tx_full` out 1: FIFO full. Reset value 0.
- `tx_empty` out 1: FIFO empty. Reset value 1.
- `wr_err` out 1: one-cycle pulse when a write is dropped. Reset value 0.
- `busy` out 1: 1 whenever state ≠ IDLE. Reset value 0.
- `txd` out 1: serial line, registered. Reset value 1.

## Operation
State machine:
- IDLE → LOAD when the FIFO is not empty.
- LOAD lasts exactly 1 cycle, then → SEND. In LOAD the block:
  - pops the FIFO head into the shift register;
  - latches `baudrate`, `parity_sel` and `stop_sel`;
  - computes the parity bit.
- SEND → IDLE at the end of the last stop bit.

Counters:
- `cnt1` counts 0..latched baudrate, then wraps to 0.
- `cnt2` is the bit index. It increments when `cnt1` equals the latched baudrate.
- Frame length is 10 + (parity≠00) + stop_sel bits, i.e. 10, 11 or 12.

Behaviour:
- Bit order on `txd`: 0 (start), d0..d7, parity if enabled, then 1 for each stop bit.
- Configuration changes during LOAD/SEND do not affect the frame in flight. They take effect at the next LOAD.
- Writes:
  - `wr_en` while `tx_full` = 1: write dropped, FIFO unchanged, `wr_err` = 1 next cycle.
  - A same-cycle pop does not make room for the write.
  - `wr_en` and a pop in the same cycle on a non-full FIFO are both performed; the count is unchanged.
- `txd` is high in IDLE and LOAD.
- Back-to-back frames: after the last stop bit, `txd` stays high for 2 extra cycles (IDLE + LOAD) before the next start bit.
- `baudrate` = 0 is legal: one `mclk` per bit.
- `n_reset` asserted mid-frame:
  - `txd` goes to 1 immediately (asynchronously);
  - FIFO contents are discarded;
  - state returns to IDLE and all counters clear.
  - No partial frame resumes after release.

## Timing
- A write at edge 0 into an empty idle block:
  - `tx_empty` falls after edge 1;
  - LOAD is entered at edge 2;
  - `txd` falls at edge 3.
- `busy` rises at edge 2 and falls at the edge that enters IDLE. That edge is one frame length × (baudrate+1) cycles after `txd` fell.
- `tx_full` and `tx_empty` are registered and updated at the same edge as the push or pop.
- The parity bit is computed in LOAD, so no combinational path runs from the FIFO to `txd`.

## Structure
- Shared package `uart_pkg` holds:
  - state encodings IDLE=0, LOAD=1, SEND=2;
  - parity codes PAR_NONE=00, PAR_EVEN=01, PAR_ODD=10, PAR_SPACE=11.
- The receiver uses the same package.
- One sub-module, `uart_tx_fifo`: synchronous FIFO with registered full/empty.
  - Its head word is valid whenever not empty (show-ahead).
  - It contains a 5-bit count and pointers that wrap modulo `FIFO_DEPTH`.
- Top-level block: FSM, `cnt1`/`cnt2`, a 12-bit frame shift register, parity logic, and `wr_err`.

## Test plan
- baudrate=3, parity 00, stop 0, write 0x55 → `txd` = 0,1,0,1,0,1,0,1,0,1 with 4 cycles per bit. `busy` lasts 40 + 1 (LOAD) cycles.
- write 0xA5 with parity 01 → parity bit 0; with parity 10 → 1; with parity 11 → 0. Frame is 11 bits.
- stop_sel=1, parity 01, write 0x01 → 12-bit frame with parity bit 1 and two high stop bits.
- 17 writes in consecutive cycles while `txd` is busy → `tx_full` after the 16th, `wr_err` pulse on the 17th. All 16 accepted bytes are then sent in order with 2-cycle inter-frame gaps.
- Change baudrate from 3 to 7 mid-frame → current frame keeps 4 cycles per bit; next frame uses 8.
- Assert `n_reset` during bit d3 → `txd` = 1, `tx_empty` = 1, `busy` = 0 immediately. No frame output after release until a new write.
